tx_symbol_source: RTL and testbench
===================================

# tx_symbol_source

Transmit-side stimulus source for the 16-QAM MER / symbol-error test bench. Generates the sample and symbol clock enables from CLOCK_50, runs a 22-bit maximal-length LFSR one step per symbol, maps 2 bits per rail onto 4-ASK levels for I and Q, and upsamples to the sample rate by zero-stuffing or zero-order hold. It drives the channel/DUT input. It also exports the raw symbol bits and the sequence-start pulse, so the receive-side slicer compare and the accumulators can align to it.

## Interface

Parameters:

- SAM_DIV, 4: CLOCK_50 cycles per sample; must be ≥1.
- SPS, 4: samples per symbol; must be ≥1.
- SEED, 22'h3FFFFF: LFSR load/reset value; must be non-zero.
- LEVEL_A, 18'sd32768: inner level "a" in 1s17. The outer level is 3·LEVEL_A = 98304.

Ports:

- CLOCK_50, input, 1: system clock. All logic runs on its rising edge.
- reset, input, 1: synchronous, active-high.
- load, input, 1: synchronous LFSR reload to SEED.
- zoh, input, 1: 1 selects zero-order hold on non-symbol samples; 0 selects zero-stuffing.
- sam_clk_en, output, 1: one-cycle sample enable.
- sym_clk_en, output, 1: one-cycle symbol enable; always coincides with a sam_clk_en.
- cycle, output, 1: one-cycle pulse marking the symbol whose LFSR state equals SEED.
- sym_bits, output, 4: LFSR bits [3:0] of the current output symbol. I uses [1:0]; Q uses [3:2].
- tx_i, output, 18 (signed, 1s17): I sample.
- tx_q, output, 18 (signed, 1s17): Q sample.

## Operation

**Reset (dominant over everything)**
- div_cnt and sam_phase are set to 0, and lfsr is set to SEED.
- All outputs are set to 0.

**Enable generation**
- div_cnt counts 0..SAM_DIV-1 and wraps.
- sam_clk_en is registered. It is high in the cycle where div_cnt has wrapped, i.e. once every SAM_DIV cycles.
- sam_phase advances 0..SPS-1 on each sam_clk_en.
- sym_clk_en is high together with sam_clk_en when sam_phase = SPS-1.
- With SAM_DIV=1, sam_clk_en is high continuously. With SPS=1, sym_clk_en equals sam_clk_en.

**LFSR**
- Fibonacci form: fb = lfsr[21]^lfsr[20], and lfsr <= {lfsr[20:0], fb}.
- It steps only on the edge that ends a sym_clk_en cycle.
- Period is 2^22-1 symbols.

**Mapper (per rail, 2 bits → level)**
- 00 → -3a (-98304)
- 01 → -a (-32768)
- 10 → +a (+32768)
- 11 → +3a (+98304)

**Symbol cycle** (edge ending a sym_clk_en cycle):
- tx_i <= map(lfsr[1:0]) and tx_q <= map(lfsr[3:2]), using the pre-step state.
- sym_bits <= lfsr[3:0].
- The LFSR then steps.

**Non-symbol sample** (sam_clk_en high, sym_clk_en low):
- tx_i/tx_q are held when zoh=1.
- tx_i/tx_q are set to 0 when zoh=0.
- sym_bits always holds.

**cycle**
- Registered, high for the one CLOCK_50 cycle after a symbol edge where the pre-step lfsr equals SEED.
- It therefore aligns with the first output sample of that symbol.

**load**
- lfsr <= SEED.
- If load is high in a sym_clk_en cycle, the outputs still register the pre-load state and the LFSR does not step. The next symbol emitted is SEED.
- Counters are not affected.
- reset has priority over load.

**zoh changes**
- Take effect at the next non-symbol sample.

## Timing

- Cycle 0 is the first rising edge with reset low.
- First sam_clk_en: high in cycle SAM_DIV-1 (cycle 3 by default), then every SAM_DIV cycles.
- First sym_clk_en: high in cycle SAM_DIV·SPS-1 (cycle 15), then every 16 cycles.
- Output latency:
  - tx_i, tx_q and sym_bits change one cycle after the enable cycle that updates them (first change in cycle 16).
  - cycle is high in cycle 16 after reset.
- Reset mid-operation: outputs are 0 in the cycle after reset is sampled high, and the cadence restarts exactly as above.
- No back-pressure: the downstream block must accept each sample on sam_clk_en.

## Test plan

1. **Reset and cadence.** Hold reset for 3 cycles, then release.
   - All outputs are 0 after reset.
   - sam_clk_en is high at cycles 3, 7, 11, 15.
   - sym_clk_en is high at cycles 15, 31, 47.
2. **First symbols with SEED=3FFFFF, zoh=0.**
   - At symbol outputs, sym_bits = F, E, C, 8.
   - tx_i = 98304, 32768, -98304, -98304.
   - tx_q = 98304, 98304, 98304, 32768.
   - tx_i and tx_q are 0 on the 3 intervening samples of each symbol.
   - cycle is high only in cycle 16.
3. **zoh=1.** The same run shows tx_i = 98304 held for all 4 samples (cycles 16–31), then 32768.
4. **load.** Pulse load coincident with the 3rd sym_clk_en.
   - The 3rd symbol is still C (-98304 / 98304).
   - The next symbols are F, E.
   - cycle pulses with the F symbol.
5. **Reset mid-stream.** Assert reset for 1 cycle at cycle 40.
   - All outputs are 0 in cycle 41.
   - The first new sym_clk_en is 15 cycles after the release edge.
   - sym_bits restarts at F.
6. **Degenerate parameters.** With SAM_DIV=1, SPS=1:
   - sam_clk_en and sym_clk_en are high every cycle after reset.
   - sym_bits follows F, E, C, 8 on consecutive cycles.

Source files
------------

// File: rtl/tx_symbol_source.sv
// 16-QAM test symbol source: sample/symbol enables, 22-bit LFSR, 4-ASK I/Q mapper, upsampler.
// Outputs register one cycle after their enable; no back-pressure, downstream takes every sam_clk_en.
module tx_symbol_source #(
  parameter int                 SAM_DIV = 4,
  parameter int                 SPS     = 4,
  parameter logic [21:0]        SEED    = 22'h3FFFFF,
  parameter logic signed [17:0] LEVEL_A = 18'sd32768
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               load,
  input  logic               zoh,
  output logic               sam_clk_en,
  output logic               sym_clk_en,
  output logic               cycle,
  output logic [3:0]         sym_bits,
  output logic signed [17:0] tx_i,
  output logic signed [17:0] tx_q
);

  localparam int DW = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1;
  localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SAM_DIV - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(SPS - 1);
  localparam logic signed [17:0] LVL_IN  = LEVEL_A;
  localparam logic signed [17:0] LVL_OUT = 18'(3 * LEVEL_A);

  logic [DW-1:0] div_cnt;
  logic [PW-1:0] sam_phase;
  logic [21:0]   lfsr;
  logic          sam_wrap;

  assign sam_wrap = (div_cnt == DIV_MAX);

  function automatic logic signed [17:0] map_lvl(input logic [1:0] b);
    case (b)
      2'b00:   map_lvl = -LVL_OUT;
      2'b01:   map_lvl = -LVL_IN;
      2'b10:   map_lvl = LVL_IN;
      default: map_lvl = LVL_OUT;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt    <= '0;
      sam_phase  <= '0;
      lfsr       <= SEED;
      sam_clk_en <= 1'b0;
      sym_clk_en <= 1'b0;
      cycle      <= 1'b0;
      sym_bits   <= '0;
      tx_i       <= '0;
      tx_q       <= '0;
    end else begin
      div_cnt    <= sam_wrap ? '0 : div_cnt + DW'(1);
      sam_clk_en <= sam_wrap;
      sym_clk_en <= sam_wrap && (sam_phase == PH_MAX);
      if (sam_wrap)
        sam_phase <= (sam_phase == PH_MAX) ? '0 : sam_phase + PW'(1);

      // Outputs always reflect the pre-step (and pre-load) LFSR state.
      cycle <= sym_clk_en && (lfsr == SEED);
      if (sym_clk_en) begin
        tx_i     <= map_lvl(lfsr[1:0]);
        tx_q     <= map_lvl(lfsr[3:2]);
        sym_bits <= lfsr[3:0];
      end else if (sam_clk_en && !zoh) begin
        tx_i <= '0;
        tx_q <= '0;
      end

      if (load)
        lfsr <= SEED;
      else if (sym_clk_en)
        lfsr <= {lfsr[20:0], lfsr[21] ^ lfsr[20]};
    end
  end

endmodule

// File: tb/tb_tx_symbol_source.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, monitors pop and compare.
module tb_tx_symbol_source;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic reset  = 1'b1;
  logic load   = 1'b0;
  logic zoh    = 1'b0;
  logic load_d = 1'b0;
  logic zoh_d  = 1'b0;

  logic m_sam, m_sym, m_cyc, d_sam, d_sym, d_cyc;
  logic [3:0] m_bits, d_bits;
  logic signed [17:0] m_i, m_q, d_i, d_q;

  tx_symbol_source dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .load(load), .zoh(zoh),
    .sam_clk_en(m_sam), .sym_clk_en(m_sym), .cycle(m_cyc),
    .sym_bits(m_bits), .tx_i(m_i), .tx_q(m_q)
  );

  tx_symbol_source #(.SAM_DIV(1), .SPS(1)) dut_deg (
    .CLOCK_50(CLOCK_50), .reset(reset), .load(load_d), .zoh(zoh_d),
    .sam_clk_en(d_sam), .sym_clk_en(d_sym), .cycle(d_cyc),
    .sym_bits(d_bits), .tx_i(d_i), .tx_q(d_q)
  );

  int tick = 0;
  always @(posedge CLOCK_50) tick <= tick + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                 t;
    int                 c;
    int                 tag;
    logic               sam;
    logic               sym;
    logic               cyc;
    logic [3:0]         bits;
    logic signed [17:0] i;
    logic signed [17:0] q;
  } exp_t;

  exp_t qm[$];
  exp_t qd[$];

  logic [3:0] syms [0:7];
  bit         pul  [0:7];

  function automatic string tag_name(input int tag);
    case (tag)
      0:       tag_name = "reset_zero";
      1:       tag_name = "run_zoh0";
      2:       tag_name = "run_zoh1";
      3:       tag_name = "after_midreset";
      4:       tag_name = "load_run";
      default: tag_name = "degenerate";
    endcase
  endfunction

  function automatic logic signed [17:0] lvl(input logic [1:0] b);
    case (b)
      2'b00:   lvl = -18'sd98304;
      2'b01:   lvl = -18'sd32768;
      2'b10:   lvl = 18'sd32768;
      default: lvl = 18'sd98304;
    endcase
  endfunction

  task automatic push_zero(input int which, input int t);
    exp_t e;
    e.t = t; e.c = -1; e.tag = 0;
    e.sam = 1'b0; e.sym = 1'b0; e.cyc = 1'b0;
    e.bits = 4'h0; e.i = '0; e.q = '0;
    if (which == 0) qm.push_back(e);
    else qd.push_back(e);
  endtask

  // Default instance: sample every 4 cycles, symbol every 16, first output at cycle 16.
  task automatic push_run(input int base, input int c_hi, input bit zoh_m, input int tag);
    exp_t e;
    int k, off;
    for (int c = 0; c <= c_hi; c++) begin
      e.t = base + c; e.c = c; e.tag = tag;
      e.sam = (c % 4 == 3);
      e.sym = (c % 16 == 15);
      e.cyc = 1'b0; e.bits = 4'h0; e.i = '0; e.q = '0;
      if (c >= 16) begin
        k   = (c - 16) / 16;
        off = (c - 16) % 16;
        e.bits = syms[k];
        e.cyc  = (off == 0) && pul[k];
        if (zoh_m || off < 4) begin
          e.i = lvl(syms[k][1:0]);
          e.q = lvl(syms[k][3:2]);
        end
      end
      qm.push_back(e);
    end
  endtask

  task automatic push_deg(input int base, input int c_hi);
    exp_t e;
    for (int c = 0; c <= c_hi; c++) begin
      e.t = base + c; e.c = c; e.tag = 5;
      e.sam = 1'b1; e.sym = 1'b1;
      e.cyc = (c == 1); e.bits = 4'h0; e.i = '0; e.q = '0;
      if (c >= 1) begin
        e.bits = syms[c-1];
        e.i    = lvl(syms[c-1][1:0]);
        e.q    = lvl(syms[c-1][3:2]);
      end
      qd.push_back(e);
    end
  endtask

  task automatic chk(input exp_t e, input logic sam, input logic sym, input logic cyc,
                     input logic [3:0] b, input logic signed [17:0] i, input logic signed [17:0] q);
    checks++;
    if (sam !== e.sam || sym !== e.sym || cyc !== e.cyc || b !== e.bits || i !== e.i || q !== e.q) begin
      errors++;
      $display("FAIL %s c=%0d: got sam=%b sym=%b cycle=%b bits=%h i=%0d q=%0d, want sam=%b sym=%b cycle=%b bits=%h i=%0d q=%0d",
               tag_name(e.tag), e.c, sam, sym, cyc, b, i, q, e.sam, e.sym, e.cyc, e.bits, e.i, e.q);
    end
  endtask

  always begin
    exp_t e;
    @(posedge CLOCK_50);
    #1;
    if (qm.size() != 0 && qm[0].t == tick) begin
      e = qm.pop_front();
      chk(e, m_sam, m_sym, m_cyc, m_bits, m_i, m_q);
    end
  end

  always begin
    exp_t e;
    @(posedge CLOCK_50);
    #1;
    if (qd.size() != 0 && qd[0].t == tick) begin
      e = qd.pop_front();
      chk(e, d_sam, d_sym, d_cyc, d_bits, d_i, d_q);
    end
  end

  task automatic at_negedge(input int t);
    do @(negedge CLOCK_50); while (tick < t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, tick=%0d", tick);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0;
    for (int t = 1; t <= 3; t++) begin
      push_zero(0, t);
      push_zero(1, t);
    end
    at_negedge(3);
    reset = 1'b0;
    base  = tick + 1;
    syms = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    pul  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    push_run(base, 95, 1'b0, 1);
    push_deg(base, 5);

    // Zero-order hold run with a one-cycle reset during cycle 40.
    at_negedge(base + 96);
    t0 = tick; reset = 1'b1; zoh = 1'b1;
    push_zero(0, t0 + 1);
    at_negedge(t0 + 1);
    reset = 1'b0;
    base  = t0 + 2;
    pul   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    push_run(base, 40, 1'b1, 2);
    push_zero(0, base + 41);
    push_run(base + 42, 47, 1'b1, 3);
    at_negedge(base + 40);
    reset = 1'b1;
    at_negedge(base + 41);
    reset = 1'b0;
    base  = base + 42;

    // Load coincident with the third symbol enable.
    at_negedge(base + 48);
    t0 = tick; reset = 1'b1; zoh = 1'b0;
    push_zero(0, t0 + 1);
    at_negedge(t0 + 1);
    reset = 1'b0;
    base  = t0 + 2;
    syms = '{4'hF, 4'hE, 4'hC, 4'hF, 4'hE, 4'h0, 4'h0, 4'h0};
    pul  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    push_run(base, 95, 1'b0, 4);
    at_negedge(base + 47);
    load = 1'b1;
    at_negedge(base + 48);
    load = 1'b0;
    at_negedge(base + 98);

    checks++;
    if (qm.size() != 0 || qd.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d/%0d unchecked entries, want 0/0", qm.size(), qd.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
